bcd_to_bin_seq: RTL and testbench
=================================

// Module: bcd_to_bin_seq
// PURPOSE
//  Sequential BCD-to-binary converter; the inverse of BCD_convert in the ALU datapath.
//  Accepts packed hundreds/tens/ones digits and returns an unsigned binary value.
//  Uses iterative reverse double-dabble: shift right, then subtract 3 from any digit >= 8.
//  Sits between keypad/BCD entry logic and the ALU operand registers.
// PARAMETERS
//  DIGITS  3   number of BCD digits in bcd_in
//  BIN_W   10  result width; must satisfy 2**BIN_W > 10**DIGITS - 1
// PORTS
//  clk      in   1         system clock, rising edge
//  rst_n    in   1         asynchronous active-low reset
//  start    in   1         request conversion; sampled only in IDLE
//  bcd_in   in   4*DIGITS  {hun,ten,one}, MS digit in the top nibble; sampled with start
//  busy     out  1         high while the conversion is in progress
//  done     out  1         one-cycle pulse when bin_out is valid
//  bin_out  out  BIN_W     result; held until the next accepted start
//  err      out  1         invalid-digit flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; busy=0, done=0, err=0, bin_out=0, work reg=0.
//  Reset mid-conversion aborts immediately; no done is produced; re-entry is to IDLE.
//  Work register is {bcd[4*DIGITS-1:0], bin[BIN_W-1:0]}; it is loaded as {bcd_in, 0}.
//  States (encoded in 2 bits):
//   IDLE: start=1 -> load work reg, clear cnt, clear err, go to CALC. Otherwise stay.
//   CALC: busy=1. Each cycle: shift work reg right by 1 (0 enters at MSB).
//         Then apply the per-digit adjust (d>=8 ? d-3 : d) to every BCD nibble.
//         cnt increments 0..BIN_W-1. At cnt==BIN_W-1 go to DONE.
//   DONE: done=1, busy=0. bin_out <= bin field (registered on DONE entry). Go to IDLE.
//  Latency: start accepted at edge N -> busy high from N+1 to N+BIN_W.
//   done is high for the single cycle after edge N+BIN_W+1 (11 cycles for BIN_W=10).
//  start while busy or in DONE: ignored. There is no queuing.
//  start held high: a new conversion begins every BIN_W+2 cycles.
//  bcd_in changes during CALC have no effect; the value is captured at acceptance only.
//  cnt width is $clog2(BIN_W); it is not allowed to wrap.
//  All arithmetic is unsigned. The nibble adjust never underflows, because a nibble >= 8 is required.
// CONFIGURATION
//  Macro BCD_ERR_CHECK_EN:
//   Defined: in IDLE with start=1, if any nibble > 9, skip CALC and go straight to DONE.
//    In that case err=1 and bin_out=0. err holds until the next accepted start.
//   Undefined: no check is made; err is tied 0; invalid nibbles convert to an undefined value.
//    Timing is unchanged in that case.
// STRUCTURE
//  Shared include bcd_defs.vh holds:
//   state localparams (S_IDLE, S_CALC, S_DONE)
//   BCD_NIB_W=4, BCD_ADJ=3, BCD_THRESH=8, BCD_MAX_DIGIT=9
//  Sub-module bcd_digit_adjust: combinational 4-bit in/out, d>=8 ? d-3 : d.
//   It is instantiated DIGITS times through a generate loop.
//  The FSM, counter and work register stay in the top module.
// TESTING
//  {0,4,5} start -> busy for 10 cycles, done pulse on cycle 11, bin_out=45, err=0.
//  {0,0,5} then {1,2,5} back to back -> bin_out=5, then bin_out=125.
//   The second start is asserted the cycle after done.
//  {9,9,9} -> 999; {0,0,0} -> 0; bin_out holds between conversions.
//  start {1,2,5}; pulse start {9,9,9} at CALC cycle 3 -> ignored; result 125.
//  start {9,9,9}; rst_n=0 at CALC cycle 5 -> busy=0 and bin_out=0 at once.
//   No done is produced. After rst_n=1, start {0,4,5} -> 45.
//  BCD_ERR_CHECK_EN defined: {0,A,5} -> done two cycles after start, err=1, bin_out=0.
//   A following {0,4,5} -> err=0, 45.
//  Loopback check: BCD_convert(bin) -> this block; all 0..999 round-trip exactly.

Source files
------------

// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared constants and FSM state encoding for the sequential BCD-to-binary converter.
package bcd_to_bin_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int BCD_NIB_W     = 4;
    localparam int BCD_ADJ       = 3;
    localparam int BCD_THRESH    = 8;
    localparam int BCD_MAX_DIGIT = 9;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Reverse double-dabble nibble correction: a digit that reached 8 or more after the
// right shift had a 10s-weight bit shifted in, so it is brought back by subtracting 3.
module bcd_digit_adjust
    import bcd_to_bin_seq_pkg::*;
(
    input  logic [BCD_NIB_W-1:0] d_i,
    output logic [BCD_NIB_W-1:0] d_o
);

    assign d_o = (d_i >= BCD_NIB_W'(BCD_THRESH)) ? (d_i - BCD_NIB_W'(BCD_ADJ)) : d_i;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Iterative BCD-to-binary converter (reverse double-dabble), one shift per cycle.
// Optional build macro BCD_ERR_CHECK_EN rejects nibbles above 9 and raises err.
module bcd_to_bin_seq
    import bcd_to_bin_seq_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [BCD_NIB_W*DIGITS-1:0] bcd_in,
    output logic                        busy,
    output logic                        done,
    output logic [BIN_W-1:0]            bin_out,
    output logic                        err
);

    localparam int BCD_W  = BCD_NIB_W * DIGITS;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int CNT_W  = $clog2(BIN_W);

    state_t              state_q;
    logic [WORK_W-1:0]   work_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    logic [BIN_W-1:0]    bin_out_q;

    logic [WORK_W-1:0]   shifted;
    logic [BCD_W-1:0]    bcd_adj;
    logic [WORK_W-1:0]   work_d;

    assign shifted = work_q >> 1;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            bcd_digit_adjust u_adj (
                .d_i (shifted[BIN_W + gi*BCD_NIB_W +: BCD_NIB_W]),
                .d_o (bcd_adj[gi*BCD_NIB_W +: BCD_NIB_W])
            );
        end
    endgenerate

    assign work_d = {bcd_adj, shifted[BIN_W-1:0]};

`ifdef BCD_ERR_CHECK_EN
    logic [DIGITS-1:0] nib_bad;
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_chk
            assign nib_bad[gi] = bcd_in[gi*BCD_NIB_W +: BCD_NIB_W] > BCD_NIB_W'(BCD_MAX_DIGIT);
        end
    endgenerate
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            work_q    <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            bin_out_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        work_q <= {bcd_in, {BIN_W{1'b0}}};
                        cnt_q  <= '0;
                        err_q  <= 1'b0;
`ifdef BCD_ERR_CHECK_EN
                        if (|nib_bad) begin
                            err_q   <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= S_CALC;
                        end
`else
                        busy_q  <= 1'b1;
                        state_q <= S_CALC;
`endif
                    end
                end
                S_CALC: begin
                    work_q <= work_d;
                    if (cnt_q == CNT_W'(BIN_W - 1)) begin
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    done_q    <= 1'b1;
                    bin_out_q <= err_q ? '0 : work_q[BIN_W-1:0];
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign bin_out = bin_out_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed bench for bcd_to_bin_seq; optional BCD_ERR_CHECK_EN build adds the invalid-digit case.
module tb_bcd_to_bin_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [11:0] bcd_in;
    logic        busy;
    logic        done;
    logic [9:0]  bin_out;
    logic        err;

    int checks = 0;
    int errors = 0;

    bcd_to_bin_seq #(.DIGITS(3), .BIN_W(10)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .bin_out (bin_out),
        .err     (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle. ncalc is the number of busy cycles expected;
    // done is expected on the sample after the DONE state. ign_at pulses a stray start.
    task automatic conv(input string tag, input logic [11:0] bcd, input logic [9:0] exp_bin,
                        input bit chk_bin, input bit exp_err, input int ncalc, input int ign_at);
        start  = 1'b1;
        bcd_in = bcd;
        for (int j = 1; j <= ncalc + 2; j++) begin
            @(negedge clk);
            if (j == 1) begin
                start  = 1'b0;
                bcd_in = 12'h000;
            end
            chk({tag, ":busy"}, busy, (j <= ncalc) ? 1 : 0);
            chk({tag, ":done"}, done, (j == ncalc + 2) ? 1 : 0);
            if (j == ign_at) begin
                start  = 1'b1;
                bcd_in = 12'h999;
            end else if (j == ign_at + 1) begin
                start = 1'b0;
            end
        end
        if (chk_bin) chk({tag, ":bin"}, bin_out, exp_bin);
        chk({tag, ":err"}, err, exp_err);
    endtask

    initial begin
        logic [11:0] lb;
        rst_n  = 1'b1;
        start  = 1'b0;
        bcd_in = 12'h000;
        #3 rst_n = 1'b0;
        #2;
        chk("rst:busy", busy, 0);
        chk("rst:done", done, 0);
        chk("rst:err", err, 0);
        chk("rst:bin", bin_out, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        conv("c045", 12'h045, 10'd45, 1, 0, 10, 0);
        @(negedge clk);
        conv("c005", 12'h005, 10'd5, 1, 0, 10, 0);
        @(negedge clk);
        conv("c125", 12'h125, 10'd125, 1, 0, 10, 0);
        @(negedge clk);
        conv("c999", 12'h999, 10'd999, 1, 0, 10, 0);
        repeat (5) @(negedge clk);
        chk("hold999", bin_out, 999);
        conv("c000", 12'h000, 10'd0, 1, 0, 10, 0);
        @(negedge clk);
        conv("ign", 12'h125, 10'd125, 1, 0, 10, 3);
        repeat (2) @(negedge clk);

        start  = 1'b1;
        bcd_in = 12'h999;
        @(negedge clk);
        start  = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort:busy", busy, 0);
        chk("abort:bin", bin_out, 0);
        chk("abort:done", done, 0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 2) rst_n = 1'b1;
            chk("abort:nodone", done, 0);
        end
        conv("post_rst", 12'h045, 10'd45, 1, 0, 10, 0);
        @(negedge clk);

`ifdef BCD_ERR_CHECK_EN
        conv("errA", 12'h0A5, 10'd0, 1, 1, 0, 0);
        @(negedge clk);
        conv("err_clr", 12'h045, 10'd45, 1, 0, 10, 0);
        @(negedge clk);
`else
        conv("noerr", 12'h0A5, 10'd0, 0, 0, 10, 0);
        @(negedge clk);
`endif

        for (int v = 0; v <= 999; v++) begin
            lb = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
            conv($sformatf("loop%0d", v), lb, 10'(v), 1, 0, 10, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
